elevator_request_scheduler: RTL

Collects hall calls and cab requests for one car and runs a SCAN (collective) policy: keep travelling in the current direction while requests lie ahead, stop at floors whose request matches that direction, then reverse or idle. Drives motor direction commands and the door, and tracks car position from a floor-arrival pulse. Sits between the button/lamp panel logic and the motor/door actuators.

---
 rtl/elevator_request_scheduler.sv | 292 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/elevator_request_scheduler.sv
// elevator_request_scheduler
// SCAN (collective) request scheduler for a single elevator car. It latches hall and
// cab requests into lamp registers. It also tracks the car floor from arrival pulses and
// drives the motor direction and door commands. All outputs are Moore, decoded from
// registered state.
// Optional feature macro: FIRE_RECALL_EN adds the fire_recall input and the recall
// behaviour. With the macro undefined, the port and the recall logic are absent.
module elevator_request_scheduler #(
    parameter int FLOORS      = 8,
    parameter int FLOOR_W     = 3,
    parameter int DOOR_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FLOORS-1:0]  call_up,
    input  logic [FLOORS-1:0]  call_dn,
    input  logic [FLOORS-1:0]  cab_req,
    input  logic               floor_arrive,
    input  logic               door_hold,
`ifdef FIRE_RECALL_EN
    input  logic               fire_recall,
`endif
    output logic               motor_up,
    output logic               motor_dn,
    output logic               door_open,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic [1:0]         dir,
    output logic [FLOORS-1:0]  lamp_up,
    output logic [FLOORS-1:0]  lamp_dn,
    output logic [FLOORS-1:0]  lamp_cab
);

    localparam int                 TMR_W     = $clog2(DOOR_CYCLES);
    localparam logic [TMR_W-1:0]   TMR_LOAD  = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] BOT_FLOOR = '0;
    // There is no up call at the top floor and no down call at the bottom floor.
    localparam logic [FLOORS-1:0]  UP_MASK   = {1'b0, {(FLOORS-1){1'b1}}};
    localparam logic [FLOORS-1:0]  DN_MASK   = {{(FLOORS-1){1'b1}}, 1'b0};
    localparam logic [FLOORS-1:0]  ONE       = FLOORS'(1);

    localparam logic [1:0] DIR_STAY = 2'd0;
    localparam logic [1:0] DIR_DN   = 2'd1;
    localparam logic [1:0] DIR_UP   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN, S_DOOR} state_t;

    state_t             r_state;
    logic [1:0]         r_dir;
    logic [FLOOR_W-1:0] r_floor;
    logic [TMR_W-1:0]   r_tmr;
    logic [FLOORS-1:0]  r_lamp_up;
    logic [FLOORS-1:0]  r_lamp_dn;
    logic [FLOORS-1:0]  r_lamp_cab;

    state_t             w_state_nxt;
    logic [1:0]         w_dir_nxt;
    logic [FLOOR_W-1:0] w_floor_nxt;
    logic [TMR_W-1:0]   w_tmr_nxt;
    logic [FLOORS-1:0]  w_set_up, w_set_dn, w_set_cab;
    logic [FLOORS-1:0]  w_clr_up, w_clr_dn, w_clr_cab;
    logic               w_absorb;

    logic [FLOORS-1:0]  w_pend;
    logic [FLOOR_W-1:0] w_nup_f, w_ndn_f;
    logic [FLOORS-1:0]  w_cur_oh, w_nup_oh, w_ndn_oh;
    logic               w_above_cur, w_below_cur, w_above_nup, w_below_ndn;

    // True when any bit of v is set at a floor strictly above f.
    function automatic logic f_above(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if ((i > int'(f)) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    // True when any bit of v is set at a floor strictly below f.
    function automatic logic f_below(input logic [FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if ((i < int'(f)) && v[i]) r = 1'b1;
        end
        return r;
    endfunction

    assign w_pend      = r_lamp_up | r_lamp_dn | r_lamp_cab;
    assign w_nup_f     = r_floor + 1'b1;
    assign w_ndn_f     = r_floor - 1'b1;
    assign w_cur_oh    = ONE << r_floor;
    assign w_nup_oh    = ONE << w_nup_f;
    assign w_ndn_oh    = ONE << w_ndn_f;
    assign w_above_cur = f_above(w_pend, r_floor);
    assign w_below_cur = f_below(w_pend, r_floor);
    assign w_above_nup = f_above(w_pend, w_nup_f);
    assign w_below_ndn = f_below(w_pend, w_ndn_f);

    // Next-state, direction, floor, timer and lamp set/clear decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_floor_nxt = r_floor;
        w_tmr_nxt   = r_tmr;
        w_set_up    = call_up & UP_MASK;
        w_set_dn    = call_dn & DN_MASK;
        w_set_cab   = cab_req;
        w_clr_up    = '0;
        w_clr_dn    = '0;
        w_clr_cab   = '0;
        w_absorb    = 1'b0;
`ifdef FIRE_RECALL_EN
        if (fire_recall) begin
            // Recall: drop all hall calls and keep cab calls pending, but do not serve them.
            w_set_up = '0;
            w_set_dn = '0;
            w_clr_up = '1;
            w_clr_dn = '1;
            case (r_state)
                S_IDLE: begin
                    if (r_floor == BOT_FLOOR) begin
                        w_state_nxt = S_DOOR;
                        w_tmr_nxt   = TMR_LOAD;
                    end else begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                    end
                end
                S_UP: begin
                    if (r_floor == TOP_FLOOR) begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                    end else if (floor_arrive) begin
                        w_floor_nxt = w_nup_f;
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                    end
                end
                S_DOWN: begin
                    if (r_floor == BOT_FLOOR) begin
                        w_state_nxt = S_DOOR;
                        w_tmr_nxt   = TMR_LOAD;
                    end else if (floor_arrive) begin
                        w_floor_nxt = w_ndn_f;
                        if (w_ndn_f == BOT_FLOOR) begin
                            w_state_nxt = S_DOOR;
                            w_tmr_nxt   = TMR_LOAD;
                        end
                    end
                end
                default: begin
                    // The door stays open at the recall floor. Elsewhere it times out, then heads down.
                    if (r_floor == BOT_FLOOR) begin
                        w_tmr_nxt = TMR_LOAD;
                    end else if (r_tmr != '0) begin
                        w_tmr_nxt = r_tmr - 1'b1;
                    end else begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                    end
                end
            endcase
        end else
`endif
        begin
            case (r_state)
                S_IDLE: begin
                    if (|(w_pend & w_cur_oh)) begin
                        w_state_nxt = S_DOOR;
                        w_tmr_nxt   = TMR_LOAD;
                        w_clr_up    = w_cur_oh;
                        w_clr_dn    = w_cur_oh;
                        w_clr_cab   = w_cur_oh;
                    end else if (w_above_cur) begin
                        w_state_nxt = S_UP;
                        w_dir_nxt   = DIR_UP;
                    end else if (w_below_cur) begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                    end
                end
                S_UP: begin
                    if (floor_arrive && (r_floor != TOP_FLOOR)) begin
                        w_floor_nxt = w_nup_f;
                        if (|(r_lamp_cab & w_nup_oh) || |(r_lamp_up & w_nup_oh) || !w_above_nup) begin
                            w_state_nxt = S_DOOR;
                            w_tmr_nxt   = TMR_LOAD;
                            w_clr_cab   = w_nup_oh;
                            if (|(r_lamp_up & w_nup_oh) || w_above_nup) begin
                                w_clr_up = w_nup_oh;
                            end else begin
                                w_clr_dn  = w_nup_oh;
                                w_dir_nxt = DIR_DN;
                            end
                        end
                    end
                end
                S_DOWN: begin
                    if (floor_arrive && (r_floor != BOT_FLOOR)) begin
                        w_floor_nxt = w_ndn_f;
                        if (|(r_lamp_cab & w_ndn_oh) || |(r_lamp_dn & w_ndn_oh) || !w_below_ndn) begin
                            w_state_nxt = S_DOOR;
                            w_tmr_nxt   = TMR_LOAD;
                            w_clr_cab   = w_ndn_oh;
                            if (|(r_lamp_dn & w_ndn_oh) || w_below_ndn) begin
                                w_clr_dn = w_ndn_oh;
                            end else begin
                                w_clr_up  = w_ndn_oh;
                                w_dir_nxt = DIR_UP;
                            end
                        end
                    end
                end
                default: begin
                    // Requests at the open door that it already satisfies are absorbed and restart the timer.
                    if (|(cab_req & w_cur_oh)) begin
                        w_set_cab = cab_req & ~w_cur_oh;
                        w_absorb  = 1'b1;
                    end
                    if ((r_dir != DIR_DN) && |(w_set_up & w_cur_oh)) begin
                        w_set_up = w_set_up & ~w_cur_oh;
                        w_absorb = 1'b1;
                    end
                    if ((r_dir != DIR_UP) && |(w_set_dn & w_cur_oh)) begin
                        w_set_dn = w_set_dn & ~w_cur_oh;
                        w_absorb = 1'b1;
                    end
                    if (door_hold || w_absorb) begin
                        w_tmr_nxt = TMR_LOAD;
                    end else if (r_tmr != '0) begin
                        w_tmr_nxt = r_tmr - 1'b1;
                    end else if ((r_dir == DIR_DN) && w_below_cur) begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                    end else if ((r_dir == DIR_DN) && w_above_cur) begin
                        w_state_nxt = S_UP;
                        w_dir_nxt   = DIR_UP;
                    end else if ((r_dir != DIR_DN) && w_above_cur) begin
                        w_state_nxt = S_UP;
                        w_dir_nxt   = DIR_UP;
                    end else if ((r_dir != DIR_DN) && w_below_cur) begin
                        w_state_nxt = S_DOWN;
                        w_dir_nxt   = DIR_DN;
                    end else if (|(w_pend & w_cur_oh)) begin
                        // Only an opposite-direction call remains here: reopen and turn around.
                        w_tmr_nxt = TMR_LOAD;
                        w_clr_up  = w_cur_oh;
                        w_clr_dn  = w_cur_oh;
                        w_clr_cab = w_cur_oh;
                        if (r_dir == DIR_UP)      w_dir_nxt = DIR_DN;
                        else if (r_dir == DIR_DN) w_dir_nxt = DIR_UP;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_dir_nxt   = DIR_STAY;
                    end
                end
            endcase
        end
    end

    // State, position, timer and lamp registers. A clear beats a set on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dir      <= DIR_STAY;
            r_floor    <= '0;
            r_tmr      <= '0;
            r_lamp_up  <= '0;
            r_lamp_dn  <= '0;
            r_lamp_cab <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir      <= w_dir_nxt;
            r_floor    <= w_floor_nxt;
            r_tmr      <= w_tmr_nxt;
            r_lamp_up  <= (r_lamp_up  | w_set_up)  & ~w_clr_up;
            r_lamp_dn  <= (r_lamp_dn  | w_set_dn)  & ~w_clr_dn;
            r_lamp_cab <= (r_lamp_cab | w_set_cab) & ~w_clr_cab;
        end
    end

    assign motor_up  = (r_state == S_UP);
    assign motor_dn  = (r_state == S_DOWN);
    assign door_open = (r_state == S_DOOR);
    assign cur_floor = r_floor;
    assign dir       = r_dir;
    assign lamp_up   = r_lamp_up;
    assign lamp_dn   = r_lamp_dn;
    assign lamp_cab  = r_lamp_cab;

endmodule
